// File: rtl/hazard_pkg.sv
// Shared constants for the hazard tracker: instruction-class T_new/T_use
// values, forward-select encodings and producer stage indices.
package hazard_pkg;

    localparam logic [1:0] TNEW_CALC_R = 2'd1;
    localparam logic [1:0] TNEW_CALC_I = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;
    localparam logic [1:0] TNEW_LINK   = 2'd0;
    localparam logic [1:0] TNEW_MF     = 2'd1;
    localparam logic [1:0] TNEW_MFC0   = 2'd2;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

    localparam int SEL_RF = 0;

    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

endpackage

// File: rtl/hazard_rec_stage.sv
// One in-flight producer record (valid, addr, tnew) for hazard_tracker.
// Records behind E count their T_new down, saturating at zero.
module hazard_rec_stage
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int T_W    = 2,
    parameter int STAGE  = STG_E
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [REG_AW-1:0] addr_i,
    input  logic [T_W-1:0]    tnew_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] addr_o,
    output logic [T_W-1:0]    tnew_o
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [T_W-1:0]    tnew_q, tnew_d;

    always_comb begin
        valid_d = valid_i & ~flush_i;
        addr_d  = addr_i;
        tnew_d  = tnew_i;
        if (STAGE != STG_E && tnew_i != '0) begin
            tnew_d = tnew_i - T_W'(1);
        end
        if (flush_i) begin
            tnew_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            tnew_q  <= tnew_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign tnew_o  = tnew_q;

endmodule

// File: rtl/hazard_tracker.sv
// Scoreboard hazard/forwarding controller: stall, D/E forward selects and
// an optional MDU busy interlock enabled by defining HAZARD_MDU_EN.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int NUM_PST = 3,
    parameter int T_W     = 2,
    parameter int MDU_LAT = 5,
    parameter int SELW    = $clog2(NUM_PST + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
    input  logic [NUM_SRC*T_W-1:0]    d_src_tuse,
    input  logic [NUM_SRC-1:0]        d_src_valid,
    input  logic [REG_AW-1:0]         d_dst_addr,
    input  logic [T_W-1:0]            d_dst_tnew,
    input  logic                      d_dst_valid,
    input  logic                      d_mdu_start,
    input  logic                      d_mdu_use,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_d_sel,
    output logic [NUM_SRC*SELW-1:0]   fwd_e_sel,
    output logic                      mdu_busy
);

    logic              cap_v;
    logic [REG_AW-1:0] cap_a;
    logic [T_W-1:0]    cap_t;

    logic              rec_v [1:NUM_PST];
    logic [REG_AW-1:0] rec_a [1:NUM_PST];
    logic [T_W-1:0]    rec_t [1:NUM_PST];

    logic [NUM_SRC-1:0] esrc_v_q, esrc_v_d;
    logic [REG_AW-1:0]  esrc_a_q [NUM_SRC];
    logic [REG_AW-1:0]  esrc_a_d [NUM_SRC];

    logic stall_data;
    logic stall_mdu;

    // A stalled D instruction enters E as a bubble.
    assign cap_v = d_dst_valid & ~stall;
    assign cap_a = d_dst_addr;
    assign cap_t = stall ? '0 : d_dst_tnew;

    for (genvar i = 1; i <= NUM_PST; i++) begin : g_rec
        logic              in_v;
        logic [REG_AW-1:0] in_a;
        logic [T_W-1:0]    in_t;

        if (i == 1) begin : g_head
            assign in_v = cap_v;
            assign in_a = cap_a;
            assign in_t = cap_t;
        end else begin : g_tail
            assign in_v = rec_v[i-1];
            assign in_a = rec_a[i-1];
            assign in_t = rec_t[i-1];
        end

        hazard_rec_stage #(
            .REG_AW (REG_AW),
            .T_W    (T_W),
            .STAGE  (i)
        ) u_rec (
            .clk_i   (clk),
            .rst_ni  (reset),
            .flush_i (flush),
            .valid_i (in_v),
            .addr_i  (in_a),
            .tnew_i  (in_t),
            .valid_o (rec_v[i]),
            .addr_o  (rec_a[i]),
            .tnew_o  (rec_t[i])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            esrc_v_d[k] = d_src_valid[k] & ~stall & ~flush;
            esrc_a_d[k] = d_src_addr[k*REG_AW +: REG_AW];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            esrc_v_q <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                esrc_a_q[k] <= '0;
            end
        end else begin
            esrc_v_q <= esrc_v_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                esrc_a_q[k] <= esrc_a_d[k];
            end
        end
    end

    // Searches run oldest to youngest so the youngest match wins.
    always_comb begin
        stall_data = 1'b0;
        fwd_d_sel  = '0;
        fwd_e_sel  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = NUM_PST; i >= 1; i--) begin
                if (rec_v[i]
                    && rec_a[i] == d_src_addr[k*REG_AW +: REG_AW]
                    && rec_a[i] != '0) begin
                    if (d_src_valid[k]
                        && rec_t[i] > d_src_tuse[k*T_W +: T_W]) begin
                        stall_data = 1'b1;
                    end
                    if (rec_t[i] == '0) begin
                        fwd_d_sel[k*SELW +: SELW] = SELW'(i);
                    end
                end
            end
            for (int i = NUM_PST; i >= 2; i--) begin
                if (esrc_v_q[k] && rec_v[i]
                    && rec_a[i] == esrc_a_q[k]
                    && rec_a[i] != '0
                    && rec_t[i] == '0) begin
                    fwd_e_sel[k*SELW +: SELW] = SELW'(i);
                end
            end
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int MCW = $clog2(MDU_LAT + 1);

    logic [MCW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic           mdu_e_q, mdu_e_d;

    always_comb begin
        mdu_e_d   = d_mdu_start & ~stall & ~flush;
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MCW'(1);
        end
        if (mdu_e_d) begin
            mdu_cnt_d = MCW'(MDU_LAT);
        end
    end

    // The counter keeps running through flushes: the MDU op is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mdu_cnt_q <= '0;
            mdu_e_q   <= 1'b0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
            mdu_e_q   <= mdu_e_d & ~flush;
        end
    end

    assign stall_mdu = d_mdu_use & ((mdu_cnt_q != '0) | mdu_e_q);
    assign mdu_busy  = (mdu_cnt_q != '0);
`else
    logic unused_mdu;

    assign unused_mdu = d_mdu_start ^ d_mdu_use ^ (MDU_LAT == 0);
    assign stall_mdu  = 1'b0;
    assign mdu_busy   = 1'b0;
`endif

    assign stall = stall_data | stall_mdu;

endmodule
